ase_emul_rd_rsp_reorder: RTL and testbench
==========================================

Name: ase_emul_rd_rsp_reorder

Overview:
Parametrised read-response reorder buffer for ASE host-channel emulation. Generalises per-port out-of-order emulation with configurable depth, selectable reorder mode, fill threshold and starvation timeout. Sits on the read-response path between the Avalon mux source port and the emulated AFU-facing port, one instance per port. Each response beat is self-identifying through its user tag, so beats are reordered independently.

Parameters:
DATA_WIDTH, 512, response data width
USER_WIDTH, 8, response user/tag width, carried unmodified with its data
DEPTH, 8, slot count; power of 2, 2..64
MODE, 1, 0 = in-order (oldest-first, no holding), 1 = pseudo-random (LFSR), 2 = newest-first
FILL_THRESH, DEPTH/2, occupancy at which release starts in modes 1/2; 1..DEPTH
MAX_HOLD, 64, age (cycles) forcing oldest-first release; 1..65534
LFSR_SEED, 16'hACE1, reset value of 16-bit LFSR; nonzero

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
rsp_in_valid  in  1  incoming response beat valid
rsp_in_data  in  DATA_WIDTH  incoming data
rsp_in_user  in  USER_WIDTH  incoming tag
rsp_in_ready  out  1  slot available
rsp_out_valid  out  1  outgoing beat valid
rsp_out_data  out  DATA_WIDTH  outgoing data
rsp_out_user  out  USER_WIDTH  outgoing tag
rsp_out_ready  in  1  downstream accepts
flush  in  1  level; forces oldest-first release, no holding
occupancy  out  clog2(DEPTH)+1  valid slots, excludes output register
stat_reordered  out  32  beats released that were not the oldest (see Optional Feature)

Behaviour:
- Reset (async assert, sync release): all slot valid bits 0; occupancy 0; rsp_out_valid 0; rsp_out_data/user 0; LFSR = LFSR_SEED; stat_reordered 0. A reset mid-operation discards all held beats.
- Storage: DEPTH slots, each with valid, data, user and a 16-bit saturating age.
- Input handshake: rsp_in_ready = (occupancy != DEPTH), derived from registered occupancy only. A beat is accepted on rsp_in_valid & rsp_in_ready and written to the lowest-index free slot with age 0.
- A slot freed in cycle N is not reusable until N+1. At full, ready stays 0 for that cycle even if a release occurs.
- Age: each valid slot's age increments every cycle and saturates at 16'hFFFF.
- Output register: rsp_out_* registered. Loads when (!rsp_out_valid | rsp_out_ready) and release_ok. Held stable while rsp_out_valid & !rsp_out_ready. The loaded slot clears in the same edge.
- Minimum latency: accept at cycle N → rsp_out_valid at N+2 (mode 0, empty buffer).
- release_ok = occupancy != 0 AND (MODE==0 OR flush OR occupancy >= FILL_THRESH OR oldest_age >= MAX_HOLD).
- Oldest = valid slot with maximum age; ties go to the lowest index.
- Selection:
  - Oldest is chosen if MODE==0, flush, or oldest_age >= MAX_HOLD.
  - Otherwise MODE 1: first valid slot at or after index LFSR[clog2(DEPTH)-1:0], scanning upward with wrap.
  - Otherwise MODE 2: valid slot with minimum age, ties to lowest index.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances only on a load.
- Simultaneous accept and load in the same cycle: both happen; occupancy is unchanged.
- Beats are never dropped or duplicated. The user tag always stays paired with its own data.

Optional Feature:
Macro ASE_EMUL_RD_RSP_REORDER_STATS_EN.
- Defined: stat_reordered increments (wrapping 32-bit) on each load whose selected slot is not the oldest.
- Undefined: stat_reordered is tied to 0 and no counter logic exists.
- All other behaviour is identical in both builds.

Test Plan:
- MODE=0, DEPTH=8: push tags 0..7 back-to-back, out_ready=1 → out tags 0..7 in order; first out_valid 2 cycles after first accept.
- MODE=2, FILL_THRESH=4: push tags 0,1,2,3 with out_ready=1 → first out tag 3 → occupancy reaches 3 (<4) so release stops → after MAX_HOLD=64 cycles tags 0,1,2 out oldest-first.
- MODE=1, DEPTH=8, 1000 random tagged beats, random out_ready → output multiset equals input; each data stays paired with its tag; stat_reordered > 0 with STATS_EN.
- Full: DEPTH=4, FILL_THRESH=4, out_ready=0 → after 4 accepts in_ready=0 and occupancy=4; raise out_ready → in_ready returns 1 the cycle after the first load.
- flush=1 with tags 5,6,7 held in MODE=1 below threshold → released 5,6,7 immediately in order.
- Assert reset with occupancy=3 and out_valid=1 → out_valid=0, occupancy=0 and in_ready=1 immediately; no stale beat after release.

Source files
------------

// File: rtl/ase_emul_rd_rsp_reorder.sv
// Read-response reorder buffer for ASE host-channel emulation: holds tagged beats in DEPTH slots
// and releases them in-order, pseudo-randomly or newest-first. Stats: ASE_EMUL_RD_RSP_REORDER_STATS_EN.
module ase_emul_rd_rsp_reorder #(
  parameter int unsigned DATA_WIDTH  = 512,
  parameter int unsigned USER_WIDTH  = 8,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned MODE        = 1,
  parameter int unsigned FILL_THRESH = DEPTH / 2,
  parameter int unsigned MAX_HOLD    = 64,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      rsp_in_valid,
  input  logic [DATA_WIDTH-1:0]     rsp_in_data,
  input  logic [USER_WIDTH-1:0]     rsp_in_user,
  output logic                      rsp_in_ready,
  output logic                      rsp_out_valid,
  output logic [DATA_WIDTH-1:0]     rsp_out_data,
  output logic [USER_WIDTH-1:0]     rsp_out_user,
  input  logic                      rsp_out_ready,
  input  logic                      flush,
  output logic [$clog2(DEPTH):0]    occupancy,
  output logic [31:0]               stat_reordered
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned OccW = IdxW + 1;

  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [15:0]           age_q [DEPTH];
  logic [15:0]           age_d [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [USER_WIDTH-1:0] user_q [DEPTH];
  logic [OccW-1:0]       occ_q, occ_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [USER_WIDTH-1:0] out_user_q, out_user_d;
  logic [15:0]           lfsr_q, lfsr_d;

  logic            free_found, oldest_found, newest_found, rnd_found;
  logic [IdxW-1:0] free_idx, oldest_idx, newest_idx, rnd_idx, scan_idx, sel_idx;
  logic [15:0]     oldest_age, newest_age;
  logic            accept, release_ok, use_oldest, load;

  assign rsp_in_ready  = (occ_q != OccW'(DEPTH));
  assign occupancy     = occ_q;
  assign rsp_out_valid = out_valid_q;
  assign rsp_out_data  = out_data_q;
  assign rsp_out_user  = out_user_q;

  // Slot search: lowest free, oldest (max age), newest (min age), first valid from LFSR start.
  always_comb begin
    free_found   = 1'b0;
    free_idx     = '0;
    oldest_found = 1'b0;
    oldest_idx   = '0;
    oldest_age   = '0;
    newest_found = 1'b0;
    newest_idx   = '0;
    newest_age   = '0;
    rnd_found    = 1'b0;
    rnd_idx      = '0;
    scan_idx     = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!valid_q[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IdxW'(i);
      end
      if (valid_q[i] && (!oldest_found || age_q[i] > oldest_age)) begin
        oldest_found = 1'b1;
        oldest_idx   = IdxW'(i);
        oldest_age   = age_q[i];
      end
      if (valid_q[i] && (!newest_found || age_q[i] < newest_age)) begin
        newest_found = 1'b1;
        newest_idx   = IdxW'(i);
        newest_age   = age_q[i];
      end
      scan_idx = lfsr_q[IdxW-1:0] + IdxW'(i);
      if (valid_q[scan_idx] && !rnd_found) begin
        rnd_found = 1'b1;
        rnd_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    use_oldest = (MODE == 0) || flush || (oldest_age >= 16'(MAX_HOLD));
    release_ok = (occ_q != '0) &&
                 (use_oldest || (occ_q >= OccW'(FILL_THRESH)));
    if (use_oldest)     sel_idx = oldest_idx;
    else if (MODE == 1) sel_idx = rnd_idx;
    else                sel_idx = newest_idx;
    accept = rsp_in_valid && rsp_in_ready;
    load   = release_ok && (!out_valid_q || rsp_out_ready);

    valid_d = valid_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      age_d[i] = (valid_q[i] && age_q[i] != 16'hFFFF) ? age_q[i] + 16'd1 : age_q[i];
    end
    // Free slot comes from registered valid bits, so a slot released now is reused next cycle.
    if (load) valid_d[sel_idx] = 1'b0;
    if (accept) begin
      valid_d[free_idx] = 1'b1;
      age_d[free_idx]   = '0;
    end
    occ_d = occ_q + OccW'(accept) - OccW'(load);

    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_user_d  = out_user_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = data_q[sel_idx];
      out_user_d  = user_q[sel_idx];
    end else if (rsp_out_ready) begin
      out_valid_d = 1'b0;
    end

    lfsr_d = lfsr_q;
    if (load) lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q     <= '0;
      occ_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_user_q  <= '0;
      lfsr_q      <= LFSR_SEED;
      for (int unsigned i = 0; i < DEPTH; i++) age_q[i] <= '0;
    end else begin
      valid_q     <= valid_d;
      occ_q       <= occ_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_user_q  <= out_user_d;
      lfsr_q      <= lfsr_d;
      for (int unsigned i = 0; i < DEPTH; i++) age_q[i] <= age_d[i];
    end
  end

  // Payload storage needs no reset; slot valid bits gate every read.
  always_ff @(posedge clk) begin
    if (accept) begin
      data_q[free_idx] <= rsp_in_data;
      user_q[free_idx] <= rsp_in_user;
    end
  end

`ifdef ASE_EMUL_RD_RSP_REORDER_STATS_EN
  logic [31:0] stat_q, stat_d;

  always_comb begin
    stat_d = stat_q;
    if (load && (sel_idx != oldest_idx)) stat_d = stat_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stat_q <= '0;
    else       stat_q <= stat_d;
  end

  assign stat_reordered = stat_q;
`else
  assign stat_reordered = '0;
`endif

endmodule

// File: tb/tb_ase_emul_rd_rsp_reorder.sv
// Directed and randomised checks of the reorder buffer across four parameterisations.
module tb_ase_emul_rd_rsp_reorder;

  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]    in_valid, out_ready, in_ready, out_valid;
  logic [DW-1:0] in_data;
  logic [7:0]    in_user;
  logic          flush;
  logic [DW-1:0] out_data [4];
  logic [7:0]    out_user [4];
  logic [31:0]   stat [4];
  logic [7:0]    occ [4];
  logic [3:0]    occ0, occ1, occ2;
  logic [2:0]    occ3;

  assign occ[0] = {4'd0, occ0};
  assign occ[1] = {4'd0, occ1};
  assign occ[2] = {4'd0, occ2};
  assign occ[3] = {5'd0, occ3};

  ase_emul_rd_rsp_reorder #(.DATA_WIDTH(DW), .USER_WIDTH(8), .DEPTH(8), .MODE(0)) u0 (
    .clk(clk), .reset(reset), .rsp_in_valid(in_valid[0]), .rsp_in_data(in_data),
    .rsp_in_user(in_user), .rsp_in_ready(in_ready[0]), .rsp_out_valid(out_valid[0]),
    .rsp_out_data(out_data[0]), .rsp_out_user(out_user[0]), .rsp_out_ready(out_ready[0]),
    .flush(flush), .occupancy(occ0), .stat_reordered(stat[0]));

  ase_emul_rd_rsp_reorder #(.DATA_WIDTH(DW), .USER_WIDTH(8), .DEPTH(8), .MODE(1)) u1 (
    .clk(clk), .reset(reset), .rsp_in_valid(in_valid[1]), .rsp_in_data(in_data),
    .rsp_in_user(in_user), .rsp_in_ready(in_ready[1]), .rsp_out_valid(out_valid[1]),
    .rsp_out_data(out_data[1]), .rsp_out_user(out_user[1]), .rsp_out_ready(out_ready[1]),
    .flush(flush), .occupancy(occ1), .stat_reordered(stat[1]));

  ase_emul_rd_rsp_reorder #(.DATA_WIDTH(DW), .USER_WIDTH(8), .DEPTH(8), .MODE(2),
                            .FILL_THRESH(4), .MAX_HOLD(64)) u2 (
    .clk(clk), .reset(reset), .rsp_in_valid(in_valid[2]), .rsp_in_data(in_data),
    .rsp_in_user(in_user), .rsp_in_ready(in_ready[2]), .rsp_out_valid(out_valid[2]),
    .rsp_out_data(out_data[2]), .rsp_out_user(out_user[2]), .rsp_out_ready(out_ready[2]),
    .flush(flush), .occupancy(occ2), .stat_reordered(stat[2]));

  ase_emul_rd_rsp_reorder #(.DATA_WIDTH(DW), .USER_WIDTH(8), .DEPTH(4), .MODE(2),
                            .FILL_THRESH(4)) u3 (
    .clk(clk), .reset(reset), .rsp_in_valid(in_valid[3]), .rsp_in_data(in_data),
    .rsp_in_user(in_user), .rsp_in_ready(in_ready[3]), .rsp_out_valid(out_valid[3]),
    .rsp_out_data(out_data[3]), .rsp_out_user(out_user[3]), .rsp_out_ready(out_ready[3]),
    .flush(flush), .occupancy(occ3), .stat_reordered(stat[3]));

  typedef struct {
    int         dut;
    bit         rb;
    bit         iv;
    logic [7:0] iu;
    bit         ordy;
    bit         fl;
    bit         ev;
    logic [7:0] eu;
    int         eocc;
    bit         erdy;
  } vec_t;

  vec_t vq[$];
  int   checks = 0;
  int   passes = 0;

  function automatic logic [DW-1:0] dfun(input logic [7:0] u);
    return {~u, u, u ^ 8'h5A, 8'hC3};
  endfunction

  function automatic vec_t mk(input int dut, input bit rb, input bit iv, input int iu,
                              input bit ordy, input bit fl, input bit ev, input int eu,
                              input int eocc, input bit erdy);
    vec_t v;
    v.dut = dut; v.rb = rb; v.iv = iv; v.iu = 8'(iu); v.ordy = ordy; v.fl = fl;
    v.ev = ev; v.eu = 8'(eu); v.eocc = eocc; v.erdy = erdy;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = '0; out_ready = '0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int n);
    logic [63:0] got, exp;
    if (v.rb) do_reset();
    in_valid = '0; out_ready = '0;
    in_valid[v.dut]  = v.iv;
    out_ready[v.dut] = v.ordy;
    in_user = v.iu; in_data = dfun(v.iu); flush = v.fl;
    @(negedge clk);
    got = {14'd0, out_valid[v.dut], (v.ev ? out_user[v.dut] : 8'h00),
           (v.ev ? out_data[v.dut] : 32'h0), occ[v.dut], in_ready[v.dut]};
    exp = {14'd0, v.ev, (v.ev ? v.eu : 8'h00), (v.ev ? dfun(v.eu) : 32'h0),
           8'(v.eocc), v.erdy};
    check($sformatf("vec%0d_dut%0d", n, v.dut), got, exp);
    @(posedge clk); #1;
  endtask

  initial begin
    int cnt [256];
    int sent, got, pair_err, dup_err, cyc, bad;

    in_valid = '0; out_ready = '0; flush = 1'b0; in_user = '0; in_data = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      check($sformatf("reset_state_dut%0d", d),
            {out_valid[d], occ[d], in_ready[d], out_data[d][15:0]},
            {1'b0, 8'd0, 1'b1, 16'h0});
    end
    check("reset_stat", stat[1], 64'd0);
    @(posedge clk); #1;

    // Mode 0: in-order, two-cycle latency.
    for (int k = 0; k < 8; k++) vq.push_back(mk(0, k == 0, 1, k, 1, 0, k >= 2, k - 2, k == 0 ? 0 : 1, 1));
    vq.push_back(mk(0, 0, 0, 0, 1, 0, 1, 6, 1, 1));
    vq.push_back(mk(0, 0, 0, 0, 1, 0, 1, 7, 0, 1));
    vq.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 1));
    // Mode 2: newest released at threshold, rest held until MAX_HOLD then oldest-first.
    for (int k = 0; k < 4; k++) vq.push_back(mk(2, k == 0, 1, k, 1, 0, 0, 0, k, 1));
    vq.push_back(mk(2, 0, 0, 0, 1, 0, 0, 0, 4, 1));
    vq.push_back(mk(2, 0, 0, 0, 1, 0, 1, 3, 3, 1));
    for (int c = 6; c <= 65; c++) vq.push_back(mk(2, 0, 0, 0, 1, 0, 0, 0, 3, 1));
    vq.push_back(mk(2, 0, 0, 0, 1, 0, 1, 0, 2, 1));
    vq.push_back(mk(2, 0, 0, 0, 1, 0, 1, 1, 1, 1));
    vq.push_back(mk(2, 0, 0, 0, 1, 0, 1, 2, 0, 1));
    vq.push_back(mk(2, 0, 0, 0, 1, 0, 0, 0, 0, 1));
    // Mode 1 flush: held beats drain oldest-first.
    for (int k = 0; k < 3; k++) vq.push_back(mk(1, k == 0, 1, 5 + k, 1, 0, 0, 0, k, 1));
    vq.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 3, 1));
    vq.push_back(mk(1, 0, 0, 0, 1, 1, 0, 0, 3, 1));
    vq.push_back(mk(1, 0, 0, 0, 1, 1, 1, 5, 2, 1));
    vq.push_back(mk(1, 0, 0, 0, 1, 1, 1, 6, 1, 1));
    vq.push_back(mk(1, 0, 0, 0, 1, 1, 1, 7, 0, 1));
    vq.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 1));
    // Full, DEPTH=4: ready low at full even while a load happens.
    for (int k = 0; k < 4; k++) vq.push_back(mk(3, k == 0, 1, 8'h10 + k, 0, 0, 0, 0, k, 1));
    vq.push_back(mk(3, 0, 1, 8'h14, 0, 0, 0, 0, 4, 0));
    vq.push_back(mk(3, 0, 1, 8'h14, 0, 0, 1, 8'h13, 3, 1));
    vq.push_back(mk(3, 0, 0, 0, 0, 0, 1, 8'h13, 4, 0));
    vq.push_back(mk(3, 0, 1, 8'h15, 1, 0, 1, 8'h13, 4, 0));
    vq.push_back(mk(3, 0, 0, 0, 0, 0, 1, 8'h14, 3, 1));
    vq.push_back(mk(3, 0, 0, 0, 1, 0, 1, 8'h14, 3, 1));
    vq.push_back(mk(3, 0, 0, 0, 1, 0, 0, 0, 3, 1));
    // Setup for mid-operation reset: occupancy 3 with output held.
    for (int k = 0; k < 4; k++) vq.push_back(mk(2, k == 0, 1, k, 0, 0, 0, 0, k, 1));
    vq.push_back(mk(2, 0, 0, 0, 0, 0, 0, 0, 4, 1));
    vq.push_back(mk(2, 0, 0, 0, 0, 0, 1, 3, 3, 1));

    foreach (vq[i]) run_vec(vq[i], i);

    #2 reset = 1'b1;
    #1 check("async_reset", {out_valid[2], occ[2], in_ready[2]}, {1'b0, 8'd0, 1'b1});
    @(posedge clk); #1 reset = 1'b0;
    in_valid = '0; out_ready = 4'b0100;
    bad = 0;
    repeat (80) begin
      @(negedge clk);
      if (out_valid[2] || occ[2] != 8'd0) bad++;
    end
    check("no_stale_after_reset", 64'(bad), 64'd0);

    // Mode 1 random traffic: multiset and tag/data pairing preserved.
    do_reset();
    for (int t = 0; t < 256; t++) cnt[t] = 0;
    sent = 0; got = 0; pair_err = 0; dup_err = 0; cyc = 0;
    while ((sent < 1000 || got < 1000) && cyc < 30000) begin
      in_valid = '0; out_ready = '0;
      in_valid[1]  = (sent < 1000) && ($urandom_range(3) != 0);
      out_ready[1] = (sent >= 1000) || ($urandom_range(1) == 1);
      flush   = (sent >= 1000);
      in_user = 8'(sent);
      in_data = dfun(in_user);
      @(negedge clk);
      if (out_valid[1] && out_ready[1]) begin
        if (out_data[1] != dfun(out_user[1])) pair_err++;
        if (cnt[out_user[1]] == 0) dup_err++;
        else cnt[out_user[1]]--;
        got++;
      end
      if (in_valid[1] && in_ready[1]) begin
        cnt[in_user]++;
        sent++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = '0; out_ready = '0; flush = 1'b0;
    check("rand_counts", {32'(sent), 32'(got)}, {32'd1000, 32'd1000});
    check("rand_pairing", 64'(pair_err), 64'd0);
    check("rand_duplicates", 64'(dup_err), 64'd0);
`ifdef ASE_EMUL_RD_RSP_REORDER_STATS_EN
    check("stat_reordered_nonzero", 64'(stat[1] != 32'd0), 64'd1);
`else
    check("stat_reordered_tied", 64'(stat[1]), 64'd0);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
